// File: rtl/serial_mag_comp_pkg.sv
// -----------------------------------------------------------------------------
// serial_mag_comp_pkg
//   Shared definitions for the serial magnitude comparator:
//   - state_t    : FSM state encoding (IDLE / CMP / DONE)
//   - result_t   : one-hot comparison result {eq, gt, lt}
//   - calc_nchunk: number of CHUNK-bit slices in a WIDTH-bit operand
//   - idx_bits   : width of a chunk index register (at least 1 bit)
// -----------------------------------------------------------------------------
package serial_mag_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } result_t;

  // Guard against a zero chunk so a bad parameter set still elaborates far
  // enough for the parameter check in the top to report it.
  function automatic int calc_nchunk(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 1;
  endfunction

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_mag_comp_comp_chunk.sv
// -----------------------------------------------------------------------------
// comp_chunk
//   Purely combinational unsigned compare of two N-bit slices.
//   Ports:
//     a, b  : slices to compare (unsigned)
//     eq    : a == b
//     gt    : a >  b
//     lt    : a <  b
// -----------------------------------------------------------------------------
module comp_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  assign eq = (a == b);
  assign gt = (a >  b);
  assign lt = (a <  b);

endmodule

// File: rtl/serial_mag_comp.sv
// -----------------------------------------------------------------------------
// serial_mag_comp
//   Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first,
//   stopping as soon as a chunk differs. Signed compares bias the sign bit
//   (invert it) on the MSB chunk so the remaining compare is unsigned.
//   Ports:
//     clk        : rising-edge clock
//     rst        : asynchronous active-high reset
//     in_valid   : operands and mode presented
//     in_ready   : block idle and accepting operands
//     a, b       : operands
//     is_signed  : 1 = two's-complement compare, 0 = unsigned
//     out_valid  : result available (held until out_ready)
//     out_ready  : consumer takes the result
//     eq, gt, lt : one-hot result, registered
// -----------------------------------------------------------------------------
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = idx_bits(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("serial_mag_comp: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
             WIDTH, CHUNK);
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  result_t          res_q, res_d;

  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             c_eq, c_gt, c_lt;

  // ---------------------------------------------------------------------------
  // Chunk select: mux the current slice out of the latched operands. On the
  // MSB chunk of a signed compare, flipping the sign bit of both operands maps
  // two's-complement order onto unsigned order.
  // ---------------------------------------------------------------------------
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = b_q[i*CHUNK +: CHUNK];
      end
    end
    if (signed_q && (idx_q == LAST_IDX)) begin
      chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
      chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
    end
  end

  comp_chunk #(
    .N (CHUNK)
  ) u_comp_chunk (
    .a  (chunk_a),
    .b  (chunk_b),
    .eq (c_eq),
    .gt (c_gt),
    .lt (c_lt)
  );

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    idx_d    = idx_q;
    res_d    = res_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          signed_d = is_signed;
          idx_d    = LAST_IDX;
          res_d    = '0;       // no stale result survives into the next op
          state_d  = CMP;
        end
      end

      CMP: begin
        if (!c_eq) begin
          res_d   = '{eq: 1'b0, gt: c_gt, lt: c_lt};
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d   = '{eq: 1'b1, gt: 1'b0, lt: 1'b0};
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers; reset clears them so an aborted compare leaves
  // nothing behind.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      res_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
    end
  end

  // Handshake outputs decode the state register only; results are registered.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign eq        = res_q.eq;
  assign gt        = res_q.gt;
  assign lt        = res_q.lt;

endmodule

// File: tb/tb_serial_mag_comp.sv
// -----------------------------------------------------------------------------
// tb_serial_mag_comp
//   Self-checking bench for serial_mag_comp (WIDTH=16, CHUNK=4). Expected
//   results come from plain integer compares; expected latency comes from the
//   position of the most significant differing chunk.
// -----------------------------------------------------------------------------
module tb_serial_mag_comp;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             eq, gt, lt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_mag_comp #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result as {eq, gt, lt}.
  function automatic logic [2:0] ref_result(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y,
                                            input logic             s);
    if (x == y) return 3'b100;
    if (s ? ($signed(x) > $signed(y)) : (x > y)) return 3'b010;
    return 3'b001;
  endfunction

  // Chunks examined: index (from the MSB end, 1-based) of the first chunk
  // where the operands differ, or all of them when equal.
  function automatic int ref_latency(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] mask;
    diff = x ^ y;
    mask = WIDTH'((1 << CHUNK) - 1);
    for (int k = 1; k <= NCHUNK; k++) begin
      if (((diff >> (WIDTH - k * CHUNK)) & mask) != '0) return k;
    end
    return NCHUNK;
  endfunction

  // One full transaction: accept, wait for the result while hammering in_valid
  // with junk, hold off the consumer for `hold` cycles, then hand off.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic s, input int hold, input string tag);
    int         cnt;
    int         exp_k;
    logic [2:0] exp_r;
    exp_r = ref_result(av, bv, s);
    exp_k = ref_latency(av, bv);

    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);

    a = av; b = bv; is_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;

    cnt = 0;
    do begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      is_signed = 1'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      cnt++;
    end while (!out_valid && cnt < NCHUNK + 4);

    check({tag, "/latency"}, 32'(cnt), 32'(exp_k));
    check({tag, "/result"}, 32'({eq, gt, lt}), 32'(exp_r));
    check({tag, "/busy"}, 32'(in_ready), 32'd0);

    for (int i = 0; i < hold; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(posedge clk); #1;
      check({tag, "/hold"}, 32'({in_ready, out_valid, eq, gt, lt}), 32'({2'b01, exp_r}));
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/handoff"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    logic             saw_valid;
    logic [WIDTH-1:0] ra, rb;
    int               mode;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({in_ready, out_valid, eq, gt, lt}), 32'b10000);
    rst = 1'b0;

    // Directed vectors; the first also proves acceptance on the first edge
    // after reset release (any delay would show in the latency count).
    run_op(16'h1234, 16'h1234, 1'b0, 0, "eq_u");
    run_op(16'h8000, 16'h7FFF, 1'b0, 0, "msb_u");
    run_op(16'h8000, 16'h7FFF, 1'b1, 0, "msb_s");
    run_op(16'h1235, 16'h1234, 1'b0, 0, "lsb_u");
    run_op(16'hFFFF, 16'hFFFE, 1'b1, 0, "neg_s");
    run_op(16'h0000, 16'hFFFF, 1'b1, 0, "zero_vs_m1");
    run_op(16'h00A0, 16'h00B0, 1'b0, 5, "backpressure");

    // Reset in the middle of a 4-chunk equal compare.
    a = 16'h5A5A; b = 16'h5A5A; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid/outputs", 32'({in_ready, out_valid, eq, gt, lt}), 32'b10000);
    #1;
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("rst_mid/no_result", 32'(saw_valid), 32'd0);
    run_op(16'd3, 16'd5, 1'b0, 1, "rst_after");

    // Randomised operands biased toward equal and near-equal pairs so every
    // early-exit depth gets exercised.
    for (int t = 0; t < 200; t++) begin
      ra   = WIDTH'($urandom);
      mode = int'($urandom_range(0, 3));
      case (mode)
        0:       rb = WIDTH'($urandom);
        1:       rb = ra;
        2:       rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: rb = ra ^ WIDTH'($urandom_range(0, (1 << CHUNK) - 1));
      endcase
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
